// File: rtl/evaluate_taper_if.sv
// rtl/evaluate_taper_if.sv - position/term handshake and score bus for evaluate_taper
interface evaluate_taper_if #(
    parameter int EVAL_WIDTH = 24,
    parameter int NUM_TERMS  = 4
);
    logic                            board_valid;
    logic                            clear_eval;
    logic                            white_to_move;
    logic [8:0]                      phase;
    logic [NUM_TERMS*EVAL_WIDTH-1:0] terms_mg;
    logic [NUM_TERMS*EVAL_WIDTH-1:0] terms_eg;
    logic [NUM_TERMS-1:0]            terms_valid;
    logic signed [EVAL_WIDTH-1:0]    eval;
    logic                            eval_valid;

    modport master (
        output board_valid, clear_eval, white_to_move, phase,
        output terms_mg, terms_eg, terms_valid,
        input  eval, eval_valid
    );

    modport slave (
        input  board_valid, clear_eval, white_to_move, phase,
        input  terms_mg, terms_eg, terms_valid,
        output eval, eval_valid
    );
endinterface

// File: rtl/evaluate_taper.sv
// rtl/evaluate_taper.sv - sums per-feature mg/eg terms and blends them by game phase
module evaluate_taper #(
    parameter int EVAL_WIDTH = 24,
    parameter int NUM_TERMS  = 4
) (
    input logic               clk,
    input logic               reset,
    evaluate_taper_if.slave   bus
);
    localparam int ACC_W = EVAL_WIDTH + 4;
    localparam int P_W   = ACC_W + 10;
    localparam int KW    = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam logic signed [P_W-1:0] MAXP = P_W'((64'sd1 <<< (EVAL_WIDTH - 1)) - 1);

    typedef enum logic [2:0] {IDLE, WAIT, SUM, MUL, OUT, DONE} state_t;

    state_t                       state;
    logic [8:0]                   ph;
    logic                         stm;
    logic [KW-1:0]                k;
    logic signed [EVAL_WIDTH-1:0] mg_q [NUM_TERMS];
    logic signed [EVAL_WIDTH-1:0] eg_q [NUM_TERMS];
    logic signed [ACC_W-1:0]      acc_mg;
    logic signed [ACC_W-1:0]      acc_eg;
    logic signed [P_W-1:0]        p_q;
    logic signed [EVAL_WIDTH-1:0] eval_q;
    logic                         eval_valid_q;

    logic signed [P_W-1:0]        r;
    logic signed [P_W-1:0]        sat;
    logic signed [EVAL_WIDTH-1:0] sat_lo;
    logic signed [EVAL_WIDTH-1:0] result;

    // Symmetric saturation keeps the side-to-move negation overflow-free.
    always_comb begin
        r = p_q >>> 8;
        sat = r;
        if (r > MAXP)
            sat = MAXP;
        else if (r < -MAXP)
            sat = -MAXP;
        sat_lo = sat[EVAL_WIDTH-1:0];
        result = stm ? sat_lo : -sat_lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ph           <= '0;
            stm          <= 1'b0;
            k            <= '0;
            acc_mg       <= '0;
            acc_eg       <= '0;
            p_q          <= '0;
            eval_q       <= '0;
            eval_valid_q <= 1'b0;
            for (int i = 0; i < NUM_TERMS; i++) begin
                mg_q[i] <= '0;
                eg_q[i] <= '0;
            end
        end else if (bus.clear_eval) begin
            state        <= IDLE;
            eval_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.board_valid) begin
                        ph    <= (bus.phase > 9'd256) ? 9'd256 : bus.phase;
                        stm   <= bus.white_to_move;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (&bus.terms_valid) begin
                        for (int i = 0; i < NUM_TERMS; i++) begin
                            mg_q[i] <= bus.terms_mg[i*EVAL_WIDTH +: EVAL_WIDTH];
                            eg_q[i] <= bus.terms_eg[i*EVAL_WIDTH +: EVAL_WIDTH];
                        end
                        acc_mg <= '0;
                        acc_eg <= '0;
                        k      <= '0;
                        state  <= SUM;
                    end
                end
                SUM: begin
                    acc_mg <= acc_mg + ACC_W'(mg_q[k]);
                    acc_eg <= acc_eg + ACC_W'(eg_q[k]);
                    k      <= k + 1'b1;
                    if (k == KW'(NUM_TERMS - 1))
                        state <= MUL;
                end
                MUL: begin
                    p_q <= P_W'(acc_mg) * P_W'($signed({1'b0, ph}))
                         + P_W'(acc_eg) * P_W'($signed({1'b0, 9'd256 - ph}));
                    state <= OUT;
                end
                OUT: begin
                    eval_q       <= result;
                    eval_valid_q <= 1'b1;
                    state        <= DONE;
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.eval       = eval_q;
    assign bus.eval_valid = eval_valid_q;
endmodule

// File: tb/tb_evaluate_taper.sv
// tb/tb_evaluate_taper.sv - directed vector bench for evaluate_taper
module tb_evaluate_taper;
    localparam int EW = 24;
    localparam int NT = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    evaluate_taper_if #(.EVAL_WIDTH(EW), .NUM_TERMS(NT)) bif ();
    evaluate_taper #(.EVAL_WIDTH(EW), .NUM_TERMS(NT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [NT*EW-1:0]  mg;
        logic [NT*EW-1:0]  eg;
        logic [8:0]        phase;
        logic              wtm;
        int                exp_eval;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [NT*EW-1:0] pack4(int a, int b, int c, int d);
        return {d[EW-1:0], c[EW-1:0], b[EW-1:0], a[EW-1:0]};
    endfunction

    task automatic check(string name, int actual, int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic start_eval(vec_t v);
        @(negedge clk);
        bif.board_valid   = 1'b1;
        bif.phase         = v.phase;
        bif.white_to_move = v.wtm;
        bif.terms_valid   = '0;
        @(negedge clk);
        bif.board_valid = 1'b0;
        bif.terms_mg    = v.mg;
        bif.terms_eg    = v.eg;
        bif.terms_valid = '1;
    endtask

    // mode 1 drops valids and scrambles the term inputs two cycles into SUM
    task automatic wait_result(string name, int expected, int mode);
        int cycles = 0;
        while (cycles < 50) begin
            @(negedge clk);
            cycles++;
            if (mode == 1 && cycles == 2) begin
                bif.terms_valid = '0;
                bif.terms_mg    = '1;
                bif.terms_eg    = '1;
            end
            if (bif.eval_valid) break;
        end
        check({name, "_latency"}, cycles, 7);
        check({name, "_eval"}, $signed(bif.eval), expected);
    endtask

    task automatic do_clear();
        @(negedge clk);
        bif.clear_eval  = 1'b1;
        bif.terms_valid = '0;
        @(negedge clk);
        bif.clear_eval = 1'b0;
    endtask

    task automatic watch(int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bif.eval_valid) seen++;
        end
    endtask

    initial begin
        int seen;
        vec_t v;
        vecs[0] = '{"mg_only",   pack4(100, -20, 5, 0), pack4(200, 0, -40, 10), 9'd256, 1'b1, 85};
        vecs[1] = '{"eg_only",   pack4(100, -20, 5, 0), pack4(200, 0, -40, 10), 9'd0,   1'b1, 170};
        vecs[2] = '{"half",      pack4(100, -20, 5, 0), pack4(200, 0, -40, 10), 9'd128, 1'b1, 127};
        vecs[3] = '{"half_blk",  pack4(100, -20, 5, 0), pack4(200, 0, -40, 10), 9'd128, 1'b0, -127};
        vecs[4] = '{"floor",     pack4(-1, 0, 0, 0),    pack4(0, 0, 0, 0),      9'd128, 1'b1, -1};
        vecs[5] = '{"clamp400",  pack4(100, -20, 5, 0), pack4(200, 0, -40, 10), 9'd400, 1'b1, 85};
        vecs[6] = '{"sat_pos",   pack4(8388607, 8388607, 8388607, 8388607), '0, 9'd256, 1'b1, 8388607};
        vecs[7] = '{"sat_neg_w", pack4(-8388608, -8388608, -8388608, -8388608), '0, 9'd256, 1'b1, -8388607};
        vecs[8] = '{"sat_neg_b", pack4(-8388608, -8388608, -8388608, -8388608), '0, 9'd256, 1'b0, 8388607};

        reset             = 1'b1;
        bif.board_valid   = 1'b0;
        bif.clear_eval    = 1'b0;
        bif.white_to_move = 1'b0;
        bif.phase         = '0;
        bif.terms_mg      = '0;
        bif.terms_eg      = '0;
        bif.terms_valid   = '0;
        repeat (3) @(negedge clk);
        check("reset_eval", $signed(bif.eval), 0);
        check("reset_valid", bif.eval_valid, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            start_eval(vecs[i]);
            wait_result(vecs[i].name, vecs[i].exp_eval, 0);
            do_clear();
            check({vecs[i].name, "_cleared"}, bif.eval_valid, 0);
        end

        // staggered valids: nothing may happen until the last bit rises
        v = vecs[0];
        @(negedge clk);
        bif.board_valid = 1'b1; bif.phase = v.phase; bif.white_to_move = v.wtm;
        @(negedge clk);
        bif.board_valid = 1'b0; bif.terms_mg = v.mg; bif.terms_eg = v.eg;
        bif.terms_valid = 4'b0001;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bif.eval_valid) seen++;
            if (i == 2) bif.terms_valid = 4'b0011;
            if (i == 5) bif.terms_valid = 4'b0111;
            if (i == 8) bif.terms_valid = 4'b1011;
        end
        check("stagger_no_progress", seen, 0);
        bif.terms_valid = 4'b1111;
        wait_result("stagger", 85, 0);
        do_clear();

        // dropped valids during SUM, then board_valid in DONE is ignored
        start_eval(vecs[2]);
        wait_result("drop_valid", 127, 1);
        @(negedge clk);
        bif.board_valid = 1'b1; bif.phase = 9'd0; bif.white_to_move = 1'b0;
        @(negedge clk);
        bif.board_valid = 1'b0; bif.terms_mg = vecs[1].mg; bif.terms_eg = vecs[1].eg;
        bif.terms_valid = '1;
        repeat (12) @(negedge clk);
        check("done_hold_valid", bif.eval_valid, 1);
        check("done_hold_eval", $signed(bif.eval), 127);
        do_clear();

        // clear in SUM aborts
        start_eval(vecs[0]);
        repeat (2) @(negedge clk);
        bif.clear_eval = 1'b1;
        @(negedge clk);
        bif.clear_eval = 1'b0;
        bif.terms_valid = '0;
        watch(12, seen);
        check("abort_sum", seen, 0);
        start_eval(vecs[3]);
        wait_result("after_abort", -127, 0);
        do_clear();

        // clear with board_valid in SUM: clear wins, FSM stays IDLE
        start_eval(vecs[0]);
        repeat (2) @(negedge clk);
        bif.clear_eval = 1'b1; bif.board_valid = 1'b1;
        @(negedge clk);
        bif.clear_eval = 1'b0; bif.board_valid = 1'b0;
        watch(12, seen);
        check("clear_beats_board", seen, 0);
        bif.terms_valid = '0;
        start_eval(vecs[4]);
        wait_result("after_clear_board", -1, 0);
        do_clear();

        // reset during MUL (cycle T+5) wipes eval, no stale result afterwards
        start_eval(vecs[1]);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mul_eval", $signed(bif.eval), 0);
        check("rst_mul_valid", bif.eval_valid, 0);
        bif.terms_valid = '0;
        watch(12, seen);
        check("rst_no_stale", seen, 0);
        start_eval(vecs[5]);
        wait_result("after_reset", 85, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/evaluate_taper.md
Name: evaluate_taper

Overview:
- Downstream aggregator for the per-feature evaluators (pawns, material, mobility, and similar).
- Collects each evaluator's signed midgame/endgame pair and sums them.
- Blends the two totals by game phase into a single tapered score.
- Outputs the score relative to the side to move, for the search core.

Parameters:
EVAL_WIDTH, 24, width of every signed term and of the final score
NUM_TERMS, 4, number of sub-evaluators feeding this block (1..16)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
board_valid  input  1  new position presented; latch phase and side to move
clear_eval  input  1  abort any evaluation, drop eval_valid
white_to_move  input  1  side to move for the latched position
phase  input  9  game phase, 0 = pure endgame, 256 = pure midgame; values >256 clamp to 256
terms_mg  input  NUM_TERMS*EVAL_WIDTH  packed signed midgame terms, term i at bits [i*EVAL_WIDTH +: EVAL_WIDTH]
terms_eg  input  NUM_TERMS*EVAL_WIDTH  packed signed endgame terms, same packing
terms_valid  input  NUM_TERMS  per-evaluator valid, level-held until that evaluator's clear
eval  output  EVAL_WIDTH  signed tapered score, side-to-move relative
eval_valid  output  1  eval holds a completed result

Behaviour:
- Reset and clear values:
  - Reset: FSM = IDLE, eval = 0, eval_valid = 0, all internal registers cleared.
  - clear_eval (any state): FSM -> IDLE, eval_valid = 0; eval keeps its old value. clear_eval beats board_valid in the same cycle.
- FSM states: IDLE, WAIT, SUM, MUL, OUT, DONE.
- IDLE:
  - On board_valid & ~clear_eval: latch min(phase,256) into ph and white_to_move into stm, then -> WAIT.
- WAIT:
  - When &terms_valid is sampled high (cycle T): capture all terms into internal registers, zero both accumulators, clear term counter k, then -> SUM.
  - Input changes after capture are ignored.
- SUM:
  - One term per cycle: acc_mg += mg[k], acc_eg += eg[k], k++.
  - After NUM_TERMS cycles -> MUL.
  - Accumulators are EVAL_WIDTH+4 bits signed, so no overflow.
- MUL (one cycle): p = acc_mg*ph + acc_eg*(256-ph), full-width signed.
- OUT (one cycle):
  - r = p >>> 8 (arithmetic shift, floor toward -inf).
  - Saturate r to [-(2^(EVAL_WIDTH-1)-1), +(2^(EVAL_WIDTH-1)-1)]; the range is symmetric so negation is safe.
  - If stm = 0, negate.
  - Register the result into eval and set eval_valid = 1. -> DONE.
- Latency: eval_valid first high in cycle T+NUM_TERMS+3 (T+7 at default).
- DONE:
  - eval and eval_valid are held until clear_eval or reset.
  - board_valid in DONE or WAIT is ignored; a clear is required first.
- terms_valid de-asserting during SUM/MUL/OUT has no effect, because terms are already captured.
- Reset or clear mid-SUM/MUL: the result is discarded and no eval_valid pulse occurs.
- board_valid and &terms_valid in the same IDLE cycle: only the latch happens; terms are sampled from the next cycle (WAIT).

Test Plan:
- Basic blend (NUM_TERMS=4):
  - Stimulus: mg={100,-20,5,0}, eg={200,0,-40,10}, white to move.
  - phase=256 -> eval=85; phase=0 -> eval=170; phase=128 -> eval=127.
  - eval_valid rises exactly 7 cycles after all valids are first sampled in WAIT.
- Side and rounding:
  - Same terms, phase=128, black to move -> eval=-127.
  - mg={-1,0,0,0}, eg=0, phase=128, white -> eval=-1 (floor behaviour).
- Clamp and saturation:
  - phase=400 behaves as 256.
  - All mg terms=8388607, phase=256 -> eval=8388607.
  - All mg terms=-8388608, white -> eval=-8388607; black -> eval=8388607.
- Handshake ordering:
  - Stagger terms_valid bits over 5 cycles -> no progress until the last bit rises.
  - Drop valids during SUM -> result unchanged.
  - board_valid while in DONE -> ignored, eval_valid stays 1.
- Abort:
  - clear_eval asserted in SUM (and separately with board_valid in the same cycle) -> eval_valid stays 0 and the FSM returns to IDLE.
  - A following board_valid plus valid terms yields a correct fresh result.
- Reset mid-MUL:
  - Assert reset during MUL -> eval=0 and eval_valid=0 next cycle.
  - No stale result appears afterwards.
